// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: per-line sync, edge capture, pending/mask, priority ID.
// Define IRQ_CTRL_DEBOUNCE_EN to add a prescaled two-sample debounce ahead of edge detection.
module irq_controller #(
  parameter logic [15:0] BASE_ADDR      = 16'hBF00,
  parameter int          NUM_IRQ        = 16,
  parameter int          DEBOUNCE_TICKS = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [15:0]        addr,
  input  logic [7:0]         wdata,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic [7:0]         rdata,
  output logic               hit,
  output logic               irq_n
);

  localparam logic [15:0] LINE_MASK = 16'((17'd1 << NUM_IRQ) - 17'd1);

  logic [NUM_IRQ-1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [NUM_IRQ-1:0] level, edge_det;
  logic [15:0]        pend_q, pend_d, mask_q, mask_d;
  logic               ctrl_q, ctrl_d, irq_n_q, irq_n_d;
  logic [15:0]        masked, clr, offset;
  logic               valid;
  logic [3:0]         idx;

  assign s1_d = irq_src;
  assign s2_d = s1_q;

`ifdef IRQ_CTRL_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_IRQ-1:0] db_a_q, db_a_d, db_b_q, db_b_d, deb_q, deb_d, agree;
  logic               tick;

  // A level is only accepted once two consecutive tick samples agree.
  always_comb begin
    tick   = (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1));
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    agree  = ~(db_a_q ^ db_b_q);
    db_a_d = db_a_q;
    db_b_d = db_b_q;
    deb_d  = deb_q;
    if (tick) begin
      db_a_d = s2_q;
      db_b_d = db_a_q;
      deb_d  = (deb_q & ~agree) | (db_a_q & agree);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      db_a_q <= '0;
      db_b_q <= '0;
      deb_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      db_a_q <= db_a_d;
      db_b_q <= db_b_d;
      deb_q  <= deb_d;
    end
  end

  assign level = deb_q;
`else
  assign level = s2_q;
`endif

  assign edge_det = level & ~prev_q;
  assign prev_d   = level;
  assign offset   = addr - BASE_ADDR;
  assign hit      = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, addr} <= ({1'b0, BASE_ADDR} + 17'd5));

  // Highest priority is the lowest-numbered enabled pending line.
  always_comb begin
    masked = pend_q & mask_q;
    valid  = ctrl_q & (|masked);
    idx    = '0;
    for (int i = 15; i >= 0; i--) begin
      if (masked[i]) idx = 4'(i);
    end
    if (!valid) idx = '0;
  end

  always_comb begin
    rdata = 8'h00;
    if (rd_en && hit) begin
      case (offset)
        16'd0:   rdata = pend_q[7:0];
        16'd1:   rdata = pend_q[15:8];
        16'd2:   rdata = mask_q[7:0];
        16'd3:   rdata = mask_q[15:8];
        16'd4:   rdata = {valid, 3'b000, idx};
        16'd5:   rdata = {7'b0, ctrl_q};
        default: rdata = 8'h00;
      endcase
    end
  end

  // New edges are OR-ed in after clears so a same-cycle set always wins.
  always_comb begin
    clr    = '0;
    mask_d = mask_q;
    ctrl_d = ctrl_q;
    if (wr_en && hit) begin
      case (offset)
        16'd0:   clr[7:0]     = wdata;
        16'd1:   clr[15:8]    = wdata;
        16'd2:   mask_d[7:0]  = wdata;
        16'd3:   mask_d[15:8] = wdata;
        16'd4:   if (valid) clr[idx] = 1'b1;
        16'd5:   ctrl_d       = wdata[0];
        default: ;
      endcase
    end
    mask_d  = mask_d & LINE_MASK;
    pend_d  = ((pend_q & ~clr) | 16'(edge_det)) & LINE_MASK;
    irq_n_d = ~valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      ctrl_q  <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      ctrl_q  <= ctrl_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign irq_n = irq_n_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized bus/line traffic
// compared against a transaction-level model of pending, mask, ctrl and the request output.
module tb_irq_controller;

  localparam logic [15:0] BASE = 16'hBF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] irqSrc;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        wrEn, rdEn;
  logic [7:0]  rdata;
  logic        hit, irqN;

  int testCount = 0;
  int failCount = 0;

  // Reference model state; srcHist[k] is the line value sampled k+1 edges ago.
  logic [15:0] mPend, mMask;
  logic        mCtrl, mIrqN;
  logic [15:0] srcHist[3];

  logic [15:0] curSrc;
  logic [7:0]  lastRead;
  logic        lastIrqN;

  irq_controller #(
    .BASE_ADDR(BASE),
    .NUM_IRQ(16),
    .DEBOUNCE_TICKS(1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .irq_src(irqSrc),
    .addr(addr),
    .wdata(wdata),
    .wr_en(wrEn),
    .rd_en(rdEn),
    .rdata(rdata),
    .hit(hit),
    .irq_n(irqN)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic int lowestBit(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int offsetOf(input logic [15:0] a);
    return int'(a) - int'(BASE);
  endfunction

  function automatic logic inWindow(input logic [15:0] a);
    int off = offsetOf(a);
    return (off >= 0) && (off <= 5);
  endfunction

  function automatic logic [7:0] modelRead(input logic [15:0] a);
    int off = offsetOf(a);
    int lo  = lowestBit(mPend & mMask);
    case (off)
      0: return mPend[7:0];
      1: return mPend[15:8];
      2: return mMask[7:0];
      3: return mMask[15:8];
      4: if (mCtrl && lo >= 0) return {4'b1000, 4'(lo)}; else return 8'h00;
      5: return {7'b0, mCtrl};
      default: return 8'h00;
    endcase
  endfunction

  task automatic modelReset();
    mPend = '0;
    mMask = '0;
    mCtrl = 1'b0;
    mIrqN = 1'b1;
    for (int i = 0; i < 3; i++) srcHist[i] = '0;
  endtask

  // One clock edge of the model: a rise seen two samples back lands in pending now.
  task automatic modelStep(input logic [15:0] src, input logic [15:0] a,
                           input logic [7:0] wd, input logic wr);
    logic [15:0] rise, clr;
    logic        nextIrqN;
    int          lo;
    nextIrqN = !(mCtrl && ((mPend & mMask) != 0));
    rise     = srcHist[1] & ~srcHist[2];
    clr      = '0;
    lo       = lowestBit(mPend & mMask);
    if (wr && inWindow(a)) begin
      case (offsetOf(a))
        0: clr = {8'h00, wd};
        1: clr = {wd, 8'h00};
        2: mMask[7:0] = wd;
        3: mMask[15:8] = wd;
        4: if (mCtrl && lo >= 0) clr = 16'(1) << lo;
        5: mCtrl = wd[0];
        default: ;
      endcase
    end
    mPend      = (mPend & ~clr) | rise;
    srcHist[2] = srcHist[1];
    srcHist[1] = srcHist[0];
    srcHist[0] = src;
    mIrqN      = nextIrqN;
  endtask

  // Drives one bus cycle starting at a falling edge; ends on the next falling edge.
  task automatic applyStimulus(input logic [15:0] src, input logic [15:0] a,
                               input logic [7:0] wd, input logic wr, input logic rd);
    irqSrc = src;
    addr   = a;
    wdata  = wd;
    wrEn   = wr;
    rdEn   = rd;
    #1;
    checkOutput("hit", 16'(hit), 16'(inWindow(a)));
    lastRead = rdata;
    if (rd) checkOutput("rdata", 16'(rdata), 16'(modelRead(a)));
    @(posedge clk);
    modelStep(src, a, wd, wr);
    @(negedge clk);
    lastIrqN = irqN;
    checkOutput("irq_n", 16'(irqN), 16'(mIrqN));
    wrEn = 1'b0;
    rdEn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(curSrc, 16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic writeReg(input int off, input logic [7:0] d);
    applyStimulus(curSrc, 16'(int'(BASE) + off), d, 1'b1, 1'b0);
  endtask

  task automatic readReg(input int off);
    applyStimulus(curSrc, 16'(int'(BASE) + off), 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    reset  = 1'b1;
    irqSrc = '0;
    addr   = '0;
    wdata  = '0;
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    curSrc = '0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("resetIrqN", 16'(irqN), 16'h1);
    reset = 1'b0;

    applyStimulus(curSrc, 16'h0000, 8'h00, 1'b0, 1'b1);
    checkOutput("resetHitZero", 16'(lastRead), 16'h00);
    for (int off = 0; off < 6; off++) readReg(off);

    writeReg(2, 8'h05);
    writeReg(5, 8'h01);
    curSrc = 16'h0004;
    idle(5);
    readReg(0);
    checkOutput("setupPendLo", 16'(lastRead), 16'h04);
    readReg(4);
    checkOutput("setupId", 16'(lastRead), 16'h82);
    checkOutput("setupIrqN", 16'(lastIrqN), 16'h0);

    curSrc = 16'h0000;
    idle(3);
    writeReg(0, 8'hFF);
    curSrc = 16'h0005;
    idle(5);
    readReg(4);
    checkOutput("prioId0", 16'(lastRead), 16'h80);
    writeReg(4, 8'h00);
    readReg(0);
    checkOutput("prioPendAfterAck", 16'(lastRead), 16'h04);
    readReg(4);
    checkOutput("prioId2", 16'(lastRead), 16'h82);
    writeReg(4, 8'h00);
    readReg(4);
    checkOutput("prioIdEmpty", 16'(lastRead), 16'h00);
    checkOutput("prioIrqNHigh", 16'(lastIrqN), 16'h1);

    curSrc = curSrc | 16'h0200;
    idle(5);
    readReg(1);
    checkOutput("maskedPendHi", 16'(lastRead), 16'h02);
    checkOutput("maskedIrqNHigh", 16'(lastIrqN), 16'h1);
    writeReg(3, 8'h02);
    idle(1);
    checkOutput("unmaskIrqNLow", 16'(lastIrqN), 16'h0);
    writeReg(1, 8'h02);
    idle(1);
    checkOutput("w1cIrqNHigh", 16'(lastIrqN), 16'h1);

    curSrc = curSrc & ~16'h0001;
    idle(3);
    curSrc = curSrc | 16'h0001;
    idle(2);
    writeReg(0, 8'h01);
    readReg(0);
    checkOutput("collisionPendLo", 16'(lastRead), 16'h01);

    applyStimulus(curSrc, BASE + 16'd6, 8'hFF, 1'b1, 1'b0);
    applyStimulus(curSrc, BASE - 16'd1, 8'hFF, 1'b1, 1'b0);
    readReg(2);
    checkOutput("decodeMaskLo", 16'(lastRead), 16'h05);
    readReg(3);
    checkOutput("decodeMaskHi", 16'(lastRead), 16'h02);
    writeReg(5, 8'hFF);
    readReg(5);
    checkOutput("ctrlBit0Only", 16'(lastRead), 16'h01);

    for (int n = 0; n < 600; n++) begin
      int op;
      if (n == 300) begin
        reset = 1'b1;
        addr  = BASE + 16'd4;
        rdEn  = 1'b1;
        #1;
        checkOutput("midResetIrqN", 16'(irqN), 16'h1);
        checkOutput("midResetId", 16'(rdata), 16'h00);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        rdEn  = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) curSrc = curSrc ^ (16'(1) << $urandom_range(0, 15));
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1:    idle(1);
        2, 3, 4: readReg(int'($urandom_range(0, 5)));
        5, 6:    writeReg(int'($urandom_range(0, 5)), 8'($urandom));
        7:       writeReg(4, 8'h00);
        8:       writeReg(int'($urandom_range(2, 3)), 8'($urandom));
        default: applyStimulus(curSrc, ($urandom_range(0, 1) == 1) ? BASE + 16'd6 : BASE - 16'd1,
                               8'($urandom), 1'b1, 1'b1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
